// File: rtl/barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shifter_pipe
//   Fully pipelined barrel shifter for the ALU datapath. Supports SRA, SLL, SRL
//   and ROR on a WIDTH-bit operand and reports the last bit shifted out. Each
//   pipeline stage applies one power-of-two shift level, so stage k shifts by
//   2^k when bit k of the amount is set. Valid/ready handshake on both sides,
//   one result per cycle at full throughput, LOG2W cycles of latency.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   pipeline can accept a request this cycle
//   in_a       operand
//   in_b       shift amount (0..WIDTH-1)
//   in_aluc    operation: 00 SRA, 01 SLL, 10 SRL, 11 ROR
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_c      shifted result
//   out_carry  last bit shifted/rotated out, 0 when the amount is 0
//   busy       any stage holds a valid entry
// -----------------------------------------------------------------------------
module barrel_shifter_pipe #(
   parameter  int WIDTH = 32,
   localparam int LOG2W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [LOG2W-1:0] in_b,
   input  logic [1:0]       in_aluc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_c,
   output logic             out_carry,
   output logic             busy
);

   if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
      $error("barrel_shifter_pipe: WIDTH must be a power of two and >= 4");
   end

   localparam logic [1:0] OP_SRA = 2'b00;
   localparam logic [1:0] OP_SLL = 2'b01;
   localparam logic [1:0] OP_SRL = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   // Stage registers
   logic [LOG2W-1:0] v_q;
   logic [WIDTH-1:0] data_q  [LOG2W];
   logic [LOG2W-1:0] b_q     [LOG2W];
   logic [1:0]       aluc_q  [LOG2W];
   logic             carry_q [LOG2W];

   // Next-state values presented to each stage
   logic             v_d     [LOG2W];
   logic [WIDTH-1:0] data_d  [LOG2W];
   logic [LOG2W-1:0] b_d     [LOG2W];
   logic [1:0]       aluc_d  [LOG2W];
   logic             carry_d [LOG2W];

   // Stage k loads this cycle (it is empty, or it is handing its entry on)
   logic [LOG2W-1:0] load;

   function automatic logic [WIDTH-1:0] level_shift(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       op,
      input int unsigned      s
   );
      level_shift = d;
      case (op)
         OP_SRA:  level_shift = $unsigned($signed(d) >>> s);
         OP_SLL:  level_shift = d << s;
         OP_SRL:  level_shift = d >> s;
         OP_ROR:  level_shift = (d >> s) | (d << (WIDTH - s));
         default: level_shift = d;
      endcase
   endfunction

   // The carry is fixed at entry from the original operand, so later stages
   // never need to know which partial shift exposed it.
   logic [LOG2W-1:0] amt_m1;
   logic [LOG2W-1:0] amt_neg;
   logic             entry_carry;

   always_comb begin
      amt_m1      = in_b - LOG2W'(1);
      amt_neg     = (~in_b) + LOG2W'(1);   // WIDTH - n, modulo WIDTH
      entry_carry = 1'b0;
      if (in_b != '0) begin
         if (in_aluc == OP_SLL) entry_carry = in_a[amt_neg];
         else                   entry_carry = in_a[amt_m1];
      end
   end

   // A stage can load when the consumer is ready or when any stage from it
   // to the output is empty: that hole absorbs the shift. Written in closed
   // form to avoid a self-referential ready chain.
   always_comb begin
      for (int k = 0; k < LOG2W; k++) begin
         load[k] = out_ready;
         for (int j = k; j < LOG2W; j++) begin
            if (!v_q[j]) load[k] = 1'b1;
         end
      end
   end

   for (genvar k = 0; k < LOG2W; k++) begin : g_stage
      logic             src_v;
      logic [WIDTH-1:0] src_d;
      logic [LOG2W-1:0] src_b;
      logic [1:0]       src_op;
      logic             src_c;

      if (k == 0) begin : g_src_in
         assign src_v  = in_valid;
         assign src_d  = in_a;
         assign src_b  = in_b;
         assign src_op = in_aluc;
         assign src_c  = entry_carry;
      end else begin : g_src_prev
         assign src_v  = v_q[k-1];
         assign src_d  = data_q[k-1];
         assign src_b  = b_q[k-1];
         assign src_op = aluc_q[k-1];
         assign src_c  = carry_q[k-1];
      end

      assign v_d[k]     = src_v;
      assign data_d[k]  = src_b[k] ? level_shift(src_d, src_op, 1 << k) : src_d;
      assign b_d[k]     = src_b;
      assign aluc_d[k]  = src_op;
      assign carry_d[k] = src_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int k = 0; k < LOG2W; k++) begin
            data_q[k]  <= '0;
            b_q[k]     <= '0;
            aluc_q[k]  <= '0;
            carry_q[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < LOG2W; k++) begin
            if (load[k]) begin
               v_q[k] <= v_d[k];
               // Payload only moves with a valid entry, so bubbles never
               // disturb what a stage last held.
               if (v_d[k]) begin
                  data_q[k]  <= data_d[k];
                  b_q[k]     <= b_d[k];
                  aluc_q[k]  <= aluc_d[k];
                  carry_q[k] <= carry_d[k];
               end
            end
         end
      end
   end

   assign in_ready  = load[0];
   assign out_valid = v_q[LOG2W-1];
   assign out_c     = data_q[LOG2W-1];
   assign out_carry = carry_q[LOG2W-1];
   assign busy      = |v_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter_pipe
//   Self-checking bench for barrel_shifter_pipe at WIDTH=32: directed vector
//   table, back-to-back streaming, back-pressure, mid-flight reset and a
//   randomized phase scored against a behavioural shift model.
// -----------------------------------------------------------------------------
module tb_barrel_shifter_pipe;

   localparam int W  = 32;
   localparam int LW = 5;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [LW-1:0] in_b;
   logic [1:0]    in_aluc;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_c;
   logic          out_carry;
   logic          busy;

   barrel_shifter_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_aluc   (in_aluc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .out_carry (out_carry),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: shifts written straight from the operation definitions.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [LW-1:0] b,
                                        input logic [1:0] op);
      int          n;
      logic [63:0] aa;
      logic [W-1:0] r;
      logic        cy;
      n = int'(b);
      case (op)
         2'b00:   r = $unsigned($signed(a) >>> n);
         2'b01:   r = a << n;
         2'b10:   r = a >> n;
         default: begin
            aa = {a, a};
            aa = aa >> n;
            r  = aa[W-1:0];
         end
      endcase
      if (n == 0)        cy = 1'b0;
      else if (op == 2'b01) cy = a[W-n];
      else               cy = a[n-1];
      return {cy, r};
   endfunction

   // Scoreboard: push on accept, pop/compare on output transfer, and check
   // that a stalled output stays put.
   logic [W:0] exp_q[$];
   logic       took     = 1'b0;
   int         acc_cnt  = 0;
   logic       stall_prev = 1'b0;
   logic [W:0] held;
   logic [W:0] e;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
         took       = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'({out_carry, out_c}), 64'(held));
         end
         stall_prev = out_valid && !out_ready;
         held       = {out_carry, out_c};
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 64'({out_carry, out_c}), 64'h1_0000_0000_0000);
            end else begin
               e = exp_q.pop_front();
               chk("result", 64'({out_carry, out_c}), 64'(e));
            end
         end
         took = in_valid && in_ready;
         if (took) begin
            exp_q.push_back(model(in_a, in_b, in_aluc));
            acc_cnt++;
         end
      end
   end

   typedef struct {
      logic [W-1:0]  a;
      logic [LW-1:0] b;
      logic [1:0]    op;
      logic [W-1:0]  c;
      logic          cy;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int cyc;
      tick();
      in_a = v.a; in_b = v.b; in_aluc = v.op; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_a = $urandom; in_b = LW'($urandom); in_aluc = 2'($urandom);
      cyc = 1;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      chk($sformatf("vec%0d_latency", idx), 64'(cyc), 64'd5);
      chk($sformatf("vec%0d_c", idx), 64'(out_c), 64'(v.c));
      chk($sformatf("vec%0d_carry", idx), 64'(out_carry), 64'(v.cy));
      tick();
   endtask

   initial begin
      int run, maxrun, total, acc0;
      logic [W:0] ref_chk;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_aluc = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_c", 64'(out_c), 64'd0);
      chk("rst_out_carry", 64'(out_carry), 64'd0);

      // Directed vectors, expected values worked out by hand
      vecs.push_back('{32'h8000_0000, 5'd4,  2'b00, 32'hF800_0000, 1'b0});
      vecs.push_back('{32'h8000_0001, 5'd1,  2'b01, 32'h0000_0002, 1'b1});
      vecs.push_back('{32'hF000_0000, 5'd28, 2'b10, 32'h0000_000F, 1'b0});
      vecs.push_back('{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000, 1'b1});
      vecs.push_back('{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1'b0});
      vecs.push_back('{32'h1234_5678, 5'd0,  2'b01, 32'h1234_5678, 1'b0});
      vecs.push_back('{32'h1234_5678, 5'd0,  2'b10, 32'h1234_5678, 1'b0});
      vecs.push_back('{32'h1234_5678, 5'd0,  2'b11, 32'h1234_5678, 1'b0});
      vecs.push_back('{32'h8000_0000, 5'd31, 2'b00, 32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{32'h7FFF_FFFF, 5'd31, 2'b00, 32'h0000_0000, 1'b1});
      vecs.push_back('{32'h0000_0003, 5'd31, 2'b01, 32'h8000_0000, 1'b1});
      vecs.push_back('{32'hFFFF_FFFF, 5'd31, 2'b10, 32'h0000_0001, 1'b1});
      vecs.push_back('{32'h1234_5678, 5'd4,  2'b11, 32'h8123_4567, 1'b1});
      vecs.push_back('{32'h0000_0001, 5'd31, 2'b11, 32'h0000_0002, 1'b0});
      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Model sanity against one hand value
      ref_chk = model(32'h8000_0000, 5'd4, 2'b00);
      chk("model_sra", 64'(ref_chk), 64'h0_F800_0000);

      // 8 back-to-back requests
      run = 0; maxrun = 0; total = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         if (cyc > 0) tick();
         if (out_valid) begin
            total++; run++;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
         in_valid = (cyc < 8);
         in_a = $urandom; in_b = LW'($urandom); in_aluc = 2'($urandom);
      end
      tick();
      chk("b2b_total", 64'(total), 64'd8);
      chk("b2b_run", 64'(maxrun), 64'd8);
      chk("b2b_drained", 64'(exp_q.size()), 64'd0);

      // Back-pressure: out_ready low for 10 cycles while streaming
      out_ready = 1'b0;
      acc0 = acc_cnt;
      in_valid = 1'b1;
      in_a = $urandom; in_b = LW'($urandom); in_aluc = 2'($urandom);
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick();
         if (took) begin
            in_a = $urandom; in_b = LW'($urandom); in_aluc = 2'($urandom);
         end
      end
      chk("bp_accepted", 64'(acc_cnt - acc0), 64'd5);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_busy", 64'(busy), 64'd1);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      repeat (12) tick();
      chk("bp_drained", 64'(exp_q.size()), 64'd0);
      chk("bp_idle", 64'(busy), 64'd0);

      // Reset with 3 entries in flight
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_a = $urandom; in_b = LW'($urandom); in_aluc = 2'($urandom);
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      chk("mrst_out_valid", 64'(out_valid), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_in_ready", 64'(in_ready), 64'd1);
      total = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick();
         if (out_valid) total++;
      end
      chk("mrst_no_ghost", 64'(total), 64'd0);

      // Randomized traffic with random back-pressure
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!in_valid || took) begin
            in_valid = ($urandom_range(3, 0) != 0);
            in_a = $urandom; in_b = LW'($urandom); in_aluc = 2'($urandom);
         end
         out_ready = ($urandom_range(2, 0) != 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (12) tick();
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      chk("rand_idle", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
